router_input_port: RTL

ROUTER_INPUT_PORT -- requirements
Module: router_input_port

---
 rtl/router_input_port_pkg.sv | 41 ++++
 rtl/router_input_port_if.sv | 25 ++
 rtl/router_input_port_xy_route_compute.sv | 30 +++
 rtl/router_input_port.sv | 106 ++++++++++
 4 files changed

// File: rtl/router_input_port_pkg.sv
// Shared flit layout, coordinate fields and output-port encodings for the mesh
// router input port and its XY route helper.
package router_input_port_pkg;

    localparam int FLIT_W        = 20;
    localparam int PAYLOAD_W     = 16;
    localparam int COORD_W       = 2;
    localparam int DEST_X_HI     = 19;
    localparam int DEST_X_LO     = 18;
    localparam int DEST_Y_HI     = 17;
    localparam int DEST_Y_LO     = 16;
    localparam int DEFAULT_DEPTH = 7;
    localparam int COUNT_W       = 3;
    localparam int NUM_PORTS     = 5;

    typedef enum logic [2:0] {
        PORT_LOCAL = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_SOUTH = 3'd2,
        PORT_EAST  = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    localparam logic [NUM_PORTS-1:0] REQ_NONE  = 5'b00000;
    localparam logic [NUM_PORTS-1:0] REQ_LOCAL = 5'b00001;
    localparam logic [NUM_PORTS-1:0] REQ_NORTH = 5'b00010;
    localparam logic [NUM_PORTS-1:0] REQ_SOUTH = 5'b00100;
    localparam logic [NUM_PORTS-1:0] REQ_EAST  = 5'b01000;
    localparam logic [NUM_PORTS-1:0] REQ_WEST  = 5'b10000;

    typedef struct packed {
        logic [COORD_W-1:0]   dest_x;
        logic [COORD_W-1:0]   dest_y;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input port_e p);
        return REQ_LOCAL << p;
    endfunction

endpackage

// File: rtl/router_input_port_if.sv
// Flit, handshake and status bundle between the upstream link / switch
// allocator (master side) and the router input port (slave side).
interface router_input_port_if;
    import router_input_port_pkg::*;

    logic [FLIT_W-1:0]    datain;
    logic                 in_valid;
    logic                 grant;
    logic [FLIT_W-1:0]    flit_out;
    logic [NUM_PORTS-1:0] req;
    logic                 co;
    logic [COUNT_W-1:0]   count;
    logic                 overflow;

    modport master (
        output datain, in_valid, grant,
        input  flit_out, req, co, count, overflow
    );

    modport slave (
        input  datain, in_valid, grant,
        output flit_out, req, co, count, overflow
    );

endinterface

// File: rtl/router_input_port_xy_route_compute.sv
// Dimension-order (X first, then Y) route decision producing a one-hot
// output-port request for one flit.
module xy_route_compute
    import router_input_port_pkg::*;
(
    input  logic [COORD_W-1:0]   dest_x_i,
    input  logic [COORD_W-1:0]   dest_y_i,
    input  logic [COORD_W-1:0]   cur_x_i,
    input  logic [COORD_W-1:0]   cur_y_i,
    output logic [NUM_PORTS-1:0] req_o
);

    port_e port_sel;

    always_comb begin
        port_sel = PORT_LOCAL;
        if (dest_x_i > cur_x_i) begin
            port_sel = PORT_EAST;
        end else if (dest_x_i < cur_x_i) begin
            port_sel = PORT_WEST;
        end else if (dest_y_i > cur_y_i) begin
            port_sel = PORT_SOUTH;
        end else if (dest_y_i < cur_y_i) begin
            port_sel = PORT_NORTH;
        end
    end

    assign req_o = port_onehot(port_sel);

endmodule

// File: rtl/router_input_port.sv
// Credit-based router input port: circular flit FIFO with XY output-port
// request on the head flit, registered credit return and sticky overflow.
module router_input_port
    import router_input_port_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic              clk,
    input  logic              rst,
    router_input_port_if.slave port_if
);

    // DEPTH is limited to 1..7 by the 3-bit count port.
    localparam int                 PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [COUNT_W-1:0] FULL_CNT = COUNT_W'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X     = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] MY_Y     = COORD_W'(Y_COORD);

    flit_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               co_q, co_d;
    logic               overflow_q, overflow_d;

    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    flit_t              head;
    logic [NUM_PORTS-1:0] head_req;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = port_if.grant && !empty;
    assign push  = port_if.in_valid && (!full || pop);
    assign drop  = port_if.in_valid && full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        co_d       = pop;
        overflow_d = overflow_q | drop;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            co_q       <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            co_q       <= co_d;
            overflow_q <= overflow_d;
        end
    end

    // Flit storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_t'(port_if.datain);
        end
    end

    assign head = mem_q[rd_ptr_q];

    xy_route_compute u_route (
        .dest_x_i (head.dest_x),
        .dest_y_i (head.dest_y),
        .cur_x_i  (MY_X),
        .cur_y_i  (MY_Y),
        .req_o    (head_req)
    );

    assign port_if.flit_out = empty ? '0 : FLIT_W'(head);
    assign port_if.req      = empty ? REQ_NONE : head_req;
    assign port_if.co       = co_q;
    assign port_if.count    = count_q;
    assign port_if.overflow = overflow_q;

endmodule
